// File: rtl/ring_decoder_if.sv
// ============================================================================
// Module      : ring_decoder_if
// Description : Sample/status bundle between a ring-code source and ring_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ring_decoder_if #(
    parameter int WIDTH = 4
) ();
    localparam int IW = $clog2(WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic             locked;
    logic             code_err;
    logic             step_err;
    logic             wrap;
    logic [15:0]      rev_count;
    logic             err_sticky;

    modport master (
        output in_valid, ring_in, clr_err,
        input  idx, idx_valid, locked, code_err, step_err, wrap, rev_count, err_sticky
    );

    modport slave (
        input  in_valid, ring_in, clr_err,
        output idx, idx_valid, locked, code_err, step_err, wrap, rev_count, err_sticky
    );
endinterface

`default_nettype wire

// File: rtl/ring_decoder.sv
// ============================================================================
// Module      : ring_decoder
// Description : One-hot ring code to binary index, with lock tracking,
//               revolution counting and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    ring_decoder_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [3:0]       good_cnt, good_cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic             idx_valid, idx_valid_nxt;
    logic             code_err, code_err_nxt;
    logic             step_err, step_err_nxt;
    logic             wrap, wrap_nxt;
    logic [15:0]      rev_count, rev_count_nxt;
    logic             err_sticky, err_sticky_nxt;

    logic             is_onehot;
    logic [IW-1:0]    code_pos;
    logic [WIDTH-1:0] exp_code;
    logic [3:0]       good_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= UNLOCKED;
            prev       <= '0;
            good_cnt   <= '0;
            idx        <= '0;
            idx_valid  <= 1'b0;
            code_err   <= 1'b0;
            step_err   <= 1'b0;
            wrap       <= 1'b0;
            rev_count  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            good_cnt   <= good_cnt_nxt;
            idx        <= idx_nxt;
            idx_valid  <= idx_valid_nxt;
            code_err   <= code_err_nxt;
            step_err   <= step_err_nxt;
            wrap       <= wrap_nxt;
            rev_count  <= rev_count_nxt;
            err_sticky <= err_sticky_nxt;
        end
    end

    always_comb begin
        // x & (x-1) clears the lowest set bit, so zero result means at most one bit
        is_onehot = (bus.ring_in != '0) &&
                    ((bus.ring_in & (bus.ring_in - WIDTH'(1))) == '0);
        code_pos  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) code_pos = IW'(i);
        end
        exp_code = {prev[0], prev[WIDTH-1:1]};
        good_inc = good_cnt + 4'd1;

        state_nxt     = state;
        prev_nxt      = prev;
        good_cnt_nxt  = good_cnt;
        idx_nxt       = idx;
        idx_valid_nxt = 1'b0;
        code_err_nxt  = 1'b0;
        step_err_nxt  = 1'b0;
        wrap_nxt      = 1'b0;
        rev_count_nxt = rev_count;

        if (bus.in_valid) begin
            if (!is_onehot) begin
                code_err_nxt = 1'b1;
                state_nxt    = UNLOCKED;
                good_cnt_nxt = '0;
            end else begin
                idx_nxt       = code_pos;
                idx_valid_nxt = 1'b1;
                prev_nxt      = bus.ring_in;
                case (state)
                    UNLOCKED: begin
                        good_cnt_nxt = '0;
                        state_nxt    = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (bus.ring_in == exp_code) begin
                            good_cnt_nxt = good_inc;
                            if (good_inc == 4'(LOCK_COUNT)) state_nxt = LOCKED;
                        end else begin
                            good_cnt_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (bus.ring_in == exp_code) begin
                            if (bus.ring_in[0]) begin
                                wrap_nxt      = 1'b1;
                                rev_count_nxt = rev_count + 16'd1;
                            end
                        end else begin
                            step_err_nxt = 1'b1;
                            good_cnt_nxt = '0;
                            state_nxt    = ACQUIRE;
                        end
                    end
                    default: begin
                        state_nxt    = UNLOCKED;
                        good_cnt_nxt = '0;
                    end
                endcase
            end
        end

        // a fresh error in the clearing cycle keeps the flag set
        err_sticky_nxt = (err_sticky & ~bus.clr_err) | code_err_nxt | step_err_nxt;
    end

    assign bus.idx        = idx;
    assign bus.idx_valid  = idx_valid;
    assign bus.locked     = (state == LOCKED);
    assign bus.code_err   = code_err;
    assign bus.step_err   = step_err;
    assign bus.wrap       = wrap;
    assign bus.rev_count  = rev_count;
    assign bus.err_sticky = err_sticky;
endmodule

`default_nettype wire

// File: tb/tb_ring_decoder.sv
// ============================================================================
// Module      : tb_ring_decoder
// Description : Scoreboard bench for ring_decoder against a position-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_decoder;
    localparam int W  = 4;
    localparam int LC = 2;
    localparam int IW = $clog2(W);

    typedef struct {
        logic [IW-1:0] idx;
        logic          idx_valid;
        logic          locked;
        logic          code_err;
        logic          step_err;
        logic          wrap;
        logic [15:0]   rev;
        logic          sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    ring_decoder_if #(.WIDTH(W)) bus ();

    ring_decoder #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // model: phase is tracked as a bit position; a correct step moves it down by one
    int m_mode;   // 0 unlocked, 1 acquiring, 2 locked
    int m_pos;
    int m_run;
    int m_idx;
    int m_rev;
    bit m_sticky;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_run = 0; m_idx = 0; m_rev = 0; m_sticky = 0;
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] code, input logic c);
        exp_t e;
        int   p;
        bit   hit;
        @(negedge clk);
        rst = r; bus.in_valid = v; bus.ring_in = code; bus.clr_err = c;
        e.idx_valid = 0; e.code_err = 0; e.step_err = 0; e.wrap = 0;
        if (r) begin
            model_reset();
        end else begin
            if (v) begin
                if ($countones(code) != 1) begin
                    e.code_err = 1;
                    m_mode = 0; m_run = 0;
                end else begin
                    p = 0;
                    for (int i = 0; i < W; i++) if (code[i]) p = i;
                    hit = (p == (m_pos + W - 1) % W);
                    e.idx_valid = 1;
                    m_idx = p;
                    if (m_mode == 0) begin
                        m_mode = 1; m_run = 0;
                    end else if (m_mode == 1) begin
                        if (hit) begin
                            m_run++;
                            if (m_run == LC) m_mode = 2;
                        end else m_run = 0;
                    end else begin
                        if (hit) begin
                            if (p == 0) begin
                                e.wrap = 1;
                                m_rev = (m_rev + 1) % 65536;
                            end
                        end else begin
                            e.step_err = 1; m_run = 0; m_mode = 1;
                        end
                    end
                    m_pos = p;
                end
            end
            m_sticky = (m_sticky && !c) || e.code_err || e.step_err;
        end
        e.idx    = IW'(m_idx);
        e.locked = (m_mode == 2);
        e.rev    = 16'(m_rev);
        e.sticky = m_sticky;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("idx",        16'(bus.idx),        16'(e.idx));
            chk("idx_valid",  16'(bus.idx_valid),  16'(e.idx_valid));
            chk("locked",     16'(bus.locked),     16'(e.locked));
            chk("code_err",   16'(bus.code_err),   16'(e.code_err));
            chk("step_err",   16'(bus.step_err),   16'(e.step_err));
            chk("wrap",       16'(bus.wrap),       16'(e.wrap));
            chk("rev_count",  bus.rev_count,       e.rev);
            chk("err_sticky", 16'(bus.err_sticky), 16'(e.sticky));
        end
    end

    task automatic good_step();
        logic [W-1:0] code;
        code = '0;
        code[(m_pos + W - 1) % W] = 1'b1;
        drive(0, 1, code, 0);
    endtask

    initial begin
        logic [W-1:0] code;
        int r;
        rst = 1; bus.in_valid = 0; bus.ring_in = '0; bus.clr_err = 0;
        model_reset();
        drive(1, 0, '0, 0);
        drive(1, 0, '0, 0);

        // lock, two revolutions, sequence break and relock
        drive(0, 1, 4'b0001, 0);
        drive(0, 1, 4'b1000, 0);
        drive(0, 1, 4'b0100, 0);
        drive(0, 1, 4'b0010, 0);
        drive(0, 1, 4'b0001, 0);
        drive(0, 1, 4'b1000, 0);
        drive(0, 1, 4'b0100, 0);
        drive(0, 1, 4'b0010, 0);
        drive(0, 1, 4'b0001, 0);
        drive(0, 1, 4'b1000, 0);
        drive(0, 1, 4'b0100, 0);
        drive(0, 1, 4'b0010, 0);
        drive(0, 1, 4'b0100, 0);
        drive(0, 1, 4'b0010, 0);
        drive(0, 1, 4'b0001, 0);
        // illegal codes and error clearing
        drive(0, 1, 4'b0000, 0);
        drive(0, 1, 4'b0110, 0);
        drive(0, 0, 4'b0000, 1);
        drive(0, 0, 4'b0000, 0);
        drive(0, 1, 4'b1111, 1);
        drive(0, 0, 4'b0000, 0);
        // gapped lock, then reset mid-turn
        drive(0, 0, 4'b0000, 1);
        for (int s = 0; s < 6; s++) begin
            if (s == 0) drive(0, 1, 4'b0100, 0);
            else        good_step();
            repeat ($urandom_range(1, 5)) drive(0, 0, 4'($urandom), 0);
        end
        drive(1, 1, 4'b0001, 1);
        drive(0, 0, 4'b0000, 0);

        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1, $urandom_range(0, 1), 4'($urandom), 0);
            end else if (r < 25) begin
                drive(0, 0, 4'($urandom), ($urandom_range(0, 19) == 0));
            end else if (r < 31) begin
                do code = 4'($urandom); while ($countones(code) == 1);
                drive(0, 1, code, ($urandom_range(0, 9) == 0));
            end else if (r < 38) begin
                code = '0;
                code[$urandom_range(0, W - 1)] = 1'b1;
                drive(0, 1, code, ($urandom_range(0, 19) == 0));
            end else begin
                good_step();
            end
        end

        drive(0, 0, '0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
